// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART ALU packet path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkt_pkg;

    localparam int HDR_BYTES = 4;

    localparam logic [7:0] OP_ECHO  = 8'hec;
    localparam logic [7:0] OP_ADD32 = 8'ha0;
    localparam logic [7:0] OP_MUL32 = 8'ha1;
    localparam logic [7:0] OP_DIV32 = 8'ha2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSVD,
        ST_LEN_L,
        ST_LEN_H,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

endpackage

// File: rtl/uart_pkt_pack.sv
// Byte-to-word packer: fills lanes from 0, emits on full word or final byte.
// Latency: word valid one clock after its last byte is accepted.
// Backpressure: single output register; hold_o tells the parser to stop accepting bytes.
module uart_pkt_pack #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_vld,
    input  logic [7:0]              in_dat,
    input  logic                    in_last,
    input  logic                    flush,
    output logic [8*WORD_BYTES-1:0] m_tdata_o,
    output logic [WORD_BYTES-1:0]   m_tkeep_o,
    output logic                    m_tlast_o,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic                    hold_o
);

    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(WORD_BYTES - 1);

    logic [LANE_W-1:0]         lane;
    logic [8*WORD_BYTES-1:0]   acc;
    logic [8*WORD_BYTES-1:0]   acc_nxt;
    logic [WORD_BYTES-1:0]     keep_nxt;
    logic                      word_done;

    assign word_done = in_vld && ((lane == LANE_MAX) || in_last);
    assign hold_o    = m_tvalid_o && !m_tready_i;

    // Merge the incoming byte into its lane and derive the keep mask for the lanes filled so far.
    always_comb begin
        acc_nxt  = acc;
        keep_nxt = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (LANE_W'(i) == lane) begin
                acc_nxt[8*i +: 8] = in_dat;
            end
            keep_nxt[i] = (LANE_W'(i) <= lane);
        end
    end

    // Accumulator and lane counter; a flush throws away a partial word without emitting it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc  <= '0;
            lane <= '0;
        end else if (flush) begin
            acc  <= '0;
            lane <= '0;
        end else if (in_vld) begin
            if (word_done) begin
                acc  <= '0;
                lane <= '0;
            end else begin
                acc  <= acc_nxt;
                lane <= lane + LANE_W'(1);
            end
        end
    end

    // Output register: reload on a completed word, otherwise clear once the consumer takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_tvalid_o <= 1'b0;
            m_tdata_o  <= '0;
            m_tkeep_o  <= '0;
            m_tlast_o  <= 1'b0;
        end else if (word_done) begin
            m_tvalid_o <= 1'b1;
            m_tdata_o  <= acc_nxt;
            m_tkeep_o  <= keep_nxt;
            m_tlast_o  <= in_last;
        end else if (m_tready_i) begin
            m_tvalid_o <= 1'b0;
            m_tdata_o  <= '0;
            m_tkeep_o  <= '0;
            m_tlast_o  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_pkt_parser.sv
// Packet parser: decodes 4-byte header, checks length, repacks payload into words, aborts on idle timeout.
// Latency: header/length-error pulses and payload words appear one clock after the completing byte.
// Backpressure: s_tready_o drops only in PAYLOAD while an output word is held; timeout frozen meanwhile.
module uart_pkt_parser
    import uart_pkt_pkg::*;
#(
    parameter int WORD_BYTES     = 4,
    parameter int MAX_LEN        = 1024,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [7:0]              s_tdata_i,
    input  logic                    s_tvalid_i,
    output logic                    s_tready_o,
    output logic                    hdr_valid_o,
    output logic [7:0]              opcode_o,
    output logic [15:0]             length_o,
    output logic [8*WORD_BYTES-1:0] m_tdata_o,
    output logic [WORD_BYTES-1:0]   m_tkeep_o,
    output logic                    m_tlast_o,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic                    err_len_o,
    output logic                    err_timeout_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] HDR_LEN = 16'(HDR_BYTES);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t             state;
    logic [7:0]         opcode_q;
    logic [7:0]         len_l_q;
    logic [15:0]        rem_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [15:0]        len_full;
    logic               hold;
    logic               byte_acc;
    logic               tmo_hit;
    logic               pay_vld;
    logic               pay_last;
    logic               pay_flush;

    assign s_tready_o = !((state == ST_PAYLOAD) && hold);
    assign byte_acc   = s_tvalid_i && s_tready_o;
    assign len_full   = {s_tdata_i, len_l_q};
    // A byte arriving on the expiry cycle wins: it restarts the idle window instead of aborting.
    assign tmo_hit    = (state != ST_IDLE) && s_tready_o && !byte_acc && (tmo_cnt == TMO_LAST);
    assign pay_vld    = byte_acc && (state == ST_PAYLOAD);
    assign pay_last   = (rem_q == 16'd1);
    assign pay_flush  = tmo_hit && (state == ST_PAYLOAD);

    // Idle counter: restarts on each accepted byte, parked in IDLE, frozen while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (byte_acc || (state == ST_IDLE) || tmo_hit) begin
            tmo_cnt <= '0;
        end else if (s_tready_o) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Header FSM with registered status pulses and held opcode/length.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_IDLE;
            opcode_q      <= '0;
            len_l_q       <= '0;
            rem_q         <= '0;
            opcode_o      <= '0;
            length_o      <= '0;
            hdr_valid_o   <= 1'b0;
            err_len_o     <= 1'b0;
            err_timeout_o <= 1'b0;
        end else begin
            hdr_valid_o   <= 1'b0;
            err_len_o     <= 1'b0;
            err_timeout_o <= 1'b0;
            if (tmo_hit) begin
                // DROP expiring is the normal way out of a bad packet, not an error.
                if (state != ST_DROP) begin
                    err_timeout_o <= 1'b1;
                end
                state <= ST_IDLE;
            end else if (byte_acc) begin
                case (state)
                    ST_IDLE: begin
                        opcode_q <= s_tdata_i;
                        state    <= ST_RSVD;
                    end
                    ST_RSVD: begin
                        state <= ST_LEN_L;
                    end
                    ST_LEN_L: begin
                        len_l_q <= s_tdata_i;
                        state   <= ST_LEN_H;
                    end
                    ST_LEN_H: begin
                        if ((len_full < HDR_LEN) || (len_full > MAX_LEN_W)) begin
                            err_len_o <= 1'b1;
                            state     <= ST_DROP;
                        end else begin
                            hdr_valid_o <= 1'b1;
                            opcode_o    <= opcode_q;
                            length_o    <= len_full;
                            rem_q       <= len_full - HDR_LEN;
                            state       <= (len_full == HDR_LEN) ? ST_IDLE : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        rem_q <= rem_q - 16'd1;
                        if (pay_last) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        state <= ST_DROP;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    uart_pkt_pack #(
        .WORD_BYTES (WORD_BYTES)
    ) u_pack (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_vld     (pay_vld),
        .in_dat     (s_tdata_i),
        .in_last    (pay_last),
        .flush      (pay_flush),
        .m_tdata_o  (m_tdata_o),
        .m_tkeep_o  (m_tkeep_o),
        .m_tlast_o  (m_tlast_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tready_i (m_tready_i),
        .hold_o     (hold)
    );

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Randomized bench for uart_pkt_parser against a chunking reference model and scoreboard.
// Latency: checks one-cycle header/word timing and exact timeout delay.
// Backpressure: drives always-ready, random and stalled downstream ready.
module tb_uart_pkt_parser;
    import uart_pkt_pkg::*;

    localparam int W    = 4;
    localparam int DW   = 8 * W;
    localparam int MAXL = 64;
    localparam int TMO  = 40;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [7:0]     s_tdata_i = '0;
    logic           s_tvalid_i = 1'b0;
    logic           s_tready_o;
    logic           hdr_valid_o;
    logic [7:0]     opcode_o;
    logic [15:0]    length_o;
    logic [DW-1:0]  m_tdata_o;
    logic [W-1:0]   m_tkeep_o;
    logic           m_tlast_o;
    logic           m_tvalid_o;
    logic           m_tready_i = 1'b0;
    logic           err_len_o;
    logic           err_timeout_o;

    uart_pkt_parser #(
        .WORD_BYTES     (W),
        .MAX_LEN        (MAXL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .s_tdata_i     (s_tdata_i),
        .s_tvalid_i    (s_tvalid_i),
        .s_tready_o    (s_tready_o),
        .hdr_valid_o   (hdr_valid_o),
        .opcode_o      (opcode_o),
        .length_o      (length_o),
        .m_tdata_o     (m_tdata_o),
        .m_tkeep_o     (m_tkeep_o),
        .m_tlast_o     (m_tlast_o),
        .m_tvalid_o    (m_tvalid_o),
        .m_tready_i    (m_tready_i),
        .err_len_o     (err_len_o),
        .err_timeout_o (err_timeout_o)
    );

    typedef struct { logic [DW-1:0] d; logic [W-1:0] k; logic l; } word_t;
    typedef struct { logic [7:0] op; logic [15:0] len; } hdr_t;

    word_t exp_w[$];
    hdr_t  exp_h[$];
    int checks = 0, failures = 0;
    int cyc = 0, last_cyc = 0, tmo_cyc = 0;
    int n_err_len = 0, n_err_tmo = 0, exp_err_len = 0, exp_tmo = 0;
    int rdy_mode = 0;   // 0 always ready, 1 random, 2 stalled

    initial forever #5 clk_i = ~clk_i;
    initial forever begin @(posedge clk_i); cyc++; end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Downstream ready driver.
    initial forever begin
        @(posedge clk_i); #1;
        case (rdy_mode)
            0: m_tready_i = 1'b1;
            1: m_tready_i = ($urandom_range(0, 3) != 0);
            default: m_tready_i = 1'b0;
        endcase
    end

    // Monitor: header events, error pulses, word scoreboard and hold stability.
    initial begin
        hdr_t  he;
        word_t we;
        logic  prev_v, prev_r;
        logic [DW+W:0] prev_d;
        prev_v = 0; prev_r = 0; prev_d = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev_v = 0;
            end else begin
                if (hdr_valid_o) begin
                    if (exp_h.size() == 0) chk("hdr_unexpected", hdr_valid_o, 0);
                    else begin
                        he = exp_h.pop_front();
                        chk("hdr_opcode", opcode_o, he.op);
                        chk("hdr_length", length_o, he.len);
                    end
                end
                if (err_len_o) n_err_len++;
                if (err_timeout_o) begin n_err_tmo++; tmo_cyc = cyc; end
                if (prev_v && !prev_r) begin
                    chk("hold_valid", m_tvalid_o, 1);
                    chk("hold_stable", {m_tlast_o, m_tkeep_o, m_tdata_o}, prev_d);
                end
                if (m_tvalid_o && m_tready_i) begin
                    if (exp_w.size() == 0) chk("word_unexpected", m_tvalid_o, 0);
                    else begin
                        we = exp_w.pop_front();
                        chk("word_data", m_tdata_o, we.d);
                        chk("word_keep", m_tkeep_o, we.k);
                        chk("word_last", m_tlast_o, we.l);
                    end
                end
                prev_v = m_tvalid_o;
                prev_r = m_tready_i;
                prev_d = {m_tlast_o, m_tkeep_o, m_tdata_o};
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 0;
        s_tdata_i  = b;
        s_tvalid_i = 1'b1;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk_i); ok = s_tready_o;
            @(posedge clk_i); #1;
        end
        s_tvalid_i = 1'b0;
        last_cyc = cyc;
        if (!ok) chk("byte_accept_timeout", ok, 1);
    endtask

    // Model: a legal packet yields one header event plus its payload cut into W-byte chunks;
    // a trailing short chunk is emitted only if it ends the packet.
    task automatic run_pkt(input logic [7:0] op, input int len, input int n_send,
                           input int max_gap, input bit fixed);
        logic [7:0]  pay[$];
        logic [15:0] l16;
        bit          legal;
        int          npay, cnt, g;
        word_t       w;
        l16   = len[15:0];
        legal = (len >= 4) && (len <= MAXL);
        npay  = legal ? len - 4 : 0;
        for (int i = 0; i < n_send; i++) pay.push_back(fixed ? 8'((i + 1) * 17) : 8'($urandom));
        if (legal) begin
            exp_h.push_back('{op, l16});
            for (int base = 0; base < n_send; base += W) begin
                cnt = (n_send - base < W) ? n_send - base : W;
                if (cnt == W || base + cnt == npay) begin
                    w.d = '0;
                    for (int j = 0; j < cnt; j++) w.d[8*j +: 8] = pay[base + j];
                    w.k = W'((1 << cnt) - 1);
                    w.l = (base + cnt == npay);
                    exp_w.push_back(w);
                end
            end
        end else begin
            exp_err_len++;
        end
        send_byte(op);
        send_byte(8'($urandom));
        send_byte(l16[7:0]);
        send_byte(l16[15:8]);
        if (legal) chk("hdr_pulse", hdr_valid_o, 1);
        else       chk("err_len_pulse", err_len_o, 1);
        for (int i = 0; i < n_send; i++) begin
            g = $urandom_range(0, max_gap);
            if (g > 0) begin repeat (g) @(posedge clk_i); #1; end
            send_byte(pay[i]);
            if (legal && ((i + 1) % W == 0 || i + 1 == npay)) chk("word_vld_timing", m_tvalid_o, 1);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && exp_w.size() != 0; k++) begin @(posedge clk_i); #1; end
        chk("drain_words", exp_w.size(), 0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got stuck expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, len_r;
        bit saw;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_tready", s_tready_o, 1);
        chk("rst_hdr_valid", hdr_valid_o, 0);
        chk("rst_tvalid", m_tvalid_o, 0);
        chk("rst_opcode", opcode_o, 0);
        chk("rst_length", length_o, 0);
        chk("rst_err_len", err_len_o, 0);
        chk("rst_err_tmo", err_timeout_o, 0);
        chk("rst_tkeep", m_tkeep_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Echo: ec 00 09 00 11 22 33 44 55.
        run_pkt(OP_ECHO, 9, 5, 0, 1);
        chk("echo_opcode", opcode_o, 8'hec);
        chk("echo_length", length_o, 9);
        drain();

        // Header only.
        run_pkt(OP_ADD32, 4, 0, 0, 0);
        repeat (3) @(posedge clk_i); #1;
        chk("hdronly_no_word", m_tvalid_o, 0);
        chk("hdronly_length", length_o, 4);

        // Short length: swallowed until timeout, silently.
        run_pkt(OP_ECHO, 2, 3, 0, 0);
        repeat (2 * TMO) @(posedge clk_i); #1;
        chk("drop_no_tmo", n_err_tmo, exp_tmo);
        run_pkt(OP_MUL32, 12, 8, 0, 0);
        drain();
        chk("after_drop_opcode", opcode_o, 8'ha1);

        // Length boundaries.
        run_pkt(OP_DIV32, MAXL + 1, 2, 0, 0);
        repeat (2 * TMO) @(posedge clk_i); #1;
        run_pkt(8'h33, 3, 1, 0, 0);
        repeat (2 * TMO) @(posedge clk_i); #1;
        run_pkt(OP_ECHO, MAXL, MAXL - 4, 1, 0);
        drain();
        chk("maxlen_length", length_o, MAXL);

        // Timeout after 6 of 12 payload bytes.
        run_pkt(OP_ADD32, 16, 6, 0, 0);
        c0 = last_cyc;
        exp_tmo++;
        for (int k = 0; k < TMO + 10 && n_err_tmo < exp_tmo; k++) begin @(posedge clk_i); #1; end
        chk("tmo_fired", n_err_tmo, exp_tmo);
        chk("tmo_delay", tmo_cyc - c0, TMO);
        chk("tmo_no_partial", m_tvalid_o, 0);
        chk("tmo_first_word", exp_w.size(), 0);

        // Downstream stall of 50 cycles mid-payload.
        saw = 0;
        fork
            run_pkt(OP_ECHO, 24, 20, 0, 0);
            begin
                repeat (8) @(posedge clk_i);
                rdy_mode = 2;
                repeat (50) begin @(negedge clk_i); if (!s_tready_o) saw = 1; end
                rdy_mode = 0;
            end
        join
        drain();
        chk("stall_tready_low", saw, 1);
        chk("stall_no_tmo", n_err_tmo, exp_tmo);

        // Random packets with random gaps and random downstream ready.
        rdy_mode = 1;
        for (int p = 0; p < 15; p++) begin
            len_r = $urandom_range(4, MAXL);
            run_pkt(8'($urandom), len_r, len_r - 4, 2, 0);
        end
        rdy_mode = 0;
        drain();

        // Async reset while a word is held.
        rdy_mode = 2;
        run_pkt(OP_MUL32, 20, 4, 0, 0);
        chk("pre_rst_held", m_tvalid_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_tvalid", m_tvalid_o, 0);
        chk("mid_rst_tready", s_tready_o, 1);
        chk("mid_rst_opcode", opcode_o, 0);
        chk("mid_rst_length", length_o, 0);
        exp_w.delete();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        rdy_mode = 0;
        @(posedge clk_i); #1;
        run_pkt(OP_ECHO, 11, 7, 1, 0);
        drain();
        chk("post_rst_opcode", opcode_o, 8'hec);

        chk("end_hdr_left", exp_h.size(), 0);
        chk("err_len_count", n_err_len, exp_err_len);
        chk("tmo_count", n_err_tmo, exp_tmo);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_pkt_parser.md
# uart_pkt_parser

Streaming packet parser for the UART ALU datapath. It sits between the byte-wide AXI-stream output of `uart_rx` and the ALU command logic. It decodes the 4-byte header (opcode, reserved, length LSB, length MSB) and repacks the payload into `WORD_BYTES`-wide words with keep and last markers. An inter-byte timeout and length checks abort malformed packets, so the host can resynchronise without a reset.

## Interface
Parameters:
- `WORD_BYTES`, 4: payload bytes per output word; ≥1.
- `MAX_LEN`, 1024: largest legal total packet length in bytes, header included; ≤65535.
- `TIMEOUT_CYCLES`, 20000: idle clocks between bytes inside a packet before abort; ≥2.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low.
- `s_tdata_i`  in  8  byte from `uart_rx`.
- `s_tvalid_i`  in  1  byte valid.
- `s_tready_o`  out  1  byte accepted when high with valid.
- `hdr_valid_o`  out  1  one-cycle pulse: header decoded and legal.
- `opcode_o`  out  8  opcode of current packet; held until next header.
- `length_o`  out  16  total length of current packet; held until next header.
- `m_tdata_o`  out  8*WORD_BYTES  payload word, byte 0 in bits [7:0].
- `m_tkeep_o`  out  WORD_BYTES  byte-valid mask, contiguous from bit 0.
- `m_tlast_o`  out  1  last payload word of packet.
- `m_tvalid_o`  out  1  word valid.
- `m_tready_i`  in  1  downstream ready.
- `err_len_o`  out  1  one-cycle pulse: length <4 or >MAX_LEN.
- `err_timeout_o`  out  1  one-cycle pulse: inter-byte timeout fired.

## Operation
- States:
  - `IDLE`: waits for first byte; the accepted byte is the opcode → `RSVD`.
  - `RSVD`: accepted byte is discarded → `LEN_L`.
  - `LEN_L` → `LEN_H`: assemble length little-endian.
  - After `LEN_H` accept:
    - length <4 or >MAX_LEN: pulse `err_len_o` → `DROP`.
    - length ==4: pulse `hdr_valid_o` → `IDLE`; no words emitted.
    - otherwise: pulse `hdr_valid_o` → `PAYLOAD` with a remaining counter = length−4.
  - `PAYLOAD`: pack bytes into the word buffer, filling from byte lane 0.
    - Word emitted when it is full or the remaining count reaches 0.
    - `tlast` set on the final word; keep = lanes filled.
    - After the final byte → `IDLE`.
  - `DROP`: accepts and discards all bytes until the timeout fires → `IDLE`; no `err_timeout_o` pulse in `DROP`.
- Timeout counter:
  - Cleared on every accepted byte; counts only outside `IDLE`.
  - Reaching TIMEOUT_CYCLES in `RSVD`/`LEN_*`/`PAYLOAD`: pulse `err_timeout_o`, discard any partial word (not emitted), → `IDLE`.
  - A word already presented on `m_*` is not retracted.
- Backpressure:
  - Single output register; `s_tready_o` = 0 in `PAYLOAD` while a word is held and `m_tready_i` = 0.
  - Otherwise `s_tready_o` = 1, including in `DROP` and during header states.
  - The timeout counter is frozen while `s_tready_o` = 0.
- Arithmetic: length and remaining counter are 16-bit unsigned; lane index is `$clog2(WORD_BYTES)` bits, wraps to 0 on each emitted word.

## Timing
- Reset values: state `IDLE`, all outputs 0 except `s_tready_o` = 1; `opcode_o`/`length_o` = 0.
- `hdr_valid_o`/`err_len_o` assert the cycle after the MSB byte handshake.
- A word's `m_tvalid_o` asserts the cycle after its last byte handshake; it holds with stable data/keep/last until `m_tready_i`.
- Word handshake and byte handshake in the same cycle:
  - The register is reloaded only if that byte completes a new word, else it clears.
  - Full throughput is one byte per clock.
- `err_timeout_o` fires exactly TIMEOUT_CYCLES clocks after the last accepted byte.
- Async reset mid-packet: all state is cleared immediately, and any held word is dropped.

## Structure
- Shared package `uart_pkt_pkg`: state enum, `HDR_BYTES` = 4, opcode constants (`OP_ECHO` = 8'hec, `OP_ADD32` = 8'ha0, `OP_MUL32` = 8'ha1, `OP_DIV32` = 8'ha2).
- One sub-module, `uart_pkt_pack`: the byte-to-word packer with lane counter, keep generation and output register.
- The FSM, length checks and timeout stay in the top.

## Test plan
- Echo packet ec 00 09 00 + 5 bytes 11..55, WORD_BYTES=4, m_tready=1 → `hdr_valid_o`, opcode ec, length 9; word 44332211 keep f last 0; then word 00000055 keep 1 last 1.
- Header-only a0 00 04 00 → `hdr_valid_o`, no `m_tvalid_o`, back in `IDLE`.
- Length 02 00 → `err_len_o` pulse; following bytes swallowed; after timeout, next packet a1 00 0c 00 + 8 bytes parses correctly.
- Stop after 6 of 12 payload bytes → `err_timeout_o` at exactly TIMEOUT_CYCLES; partial word not emitted; the first full word was emitted earlier.
- Hold `m_tready_i` = 0 for 50 cycles mid-payload → `s_tready_o` drops, no byte lost, no timeout; data intact after release.
- Assert `rst_ni` low mid-payload → outputs return to reset values within the same cycle; next packet parses normally.
